// File: rtl/nxu8_target.sv
// nX-U8 debug-port target: decodes host frames into register read/write strobes.
// Optional mid-frame abort timeout is compiled in when NXU8_TARGET_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module nxu8_target #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_nx_clk,
    input  logic        i_nx_data,
    output logic        o_nx_data,
    output logic        o_nx_data_oe,
    output logic [6:0]  o_reg_addr,
    output logic [15:0] o_reg_wdata,
    output logic        o_reg_we,
    output logic        o_reg_re,
    input  logic [15:0] i_reg_rdata,
    output logic        o_busy,
    output logic        o_frame_err
);

    typedef enum logic [1:0] {
        s_HDR,
        s_WDATA,
        s_TURN,
        s_RDATA
    } state_t;

    logic        nx_clk_meta_q,  nx_clk_meta_d;
    logic        nx_clk_sync_q,  nx_clk_sync_d;
    logic        nx_clk_prev_q,  nx_clk_prev_d;
    logic        nx_data_meta_q, nx_data_meta_d;
    logic        nx_data_sync_q, nx_data_sync_d;
    state_t      state_q,        state_d;
    logic [3:0]  cnt_q,          cnt_d;
    logic [15:0] shift_q,        shift_d;
    logic        cap_pend_q,     cap_pend_d;
    logic [6:0]  addr_q,         addr_d;
    logic [15:0] wdata_q,        wdata_d;
    logic        we_q,           we_d;
    logic        re_q,           re_d;
    logic        nx_data_q,      nx_data_d;
    logic        oe_q,           oe_d;

    logic rise;
    logic fall;
    logic busy;

    assign rise = nx_clk_sync_q & ~nx_clk_prev_q;
    assign fall = ~nx_clk_sync_q & nx_clk_prev_q;
    assign busy = (state_q != s_HDR) || (cnt_q != 4'd0);

`ifdef NXU8_TARGET_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              frame_err_q, frame_err_d;
`else
    // Keeps the parameter referenced when the abort timeout is compiled out.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_comb begin
        // NOTE: every _d takes a default before any branch so no path can infer a latch.
        nx_clk_meta_d  = i_nx_clk;
        nx_clk_sync_d  = nx_clk_meta_q;
        nx_clk_prev_d  = nx_clk_sync_q;
        nx_data_meta_d = i_nx_data;
        nx_data_sync_d = nx_data_meta_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        cap_pend_d     = 1'b0;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        we_d           = 1'b0;
        re_d           = 1'b0;
        nx_data_d      = nx_data_q;
        oe_d           = (state_q == s_RDATA) ? oe_q : 1'b0;

        case (state_q)
            s_HDR: begin
                if (rise) begin
                    shift_d = {shift_q[14:0], nx_data_sync_q};
                    if (cnt_q == 4'd7) begin
                        // Header is {shift_q[6:0], current bit}; bit7 selects write.
                        addr_d = {shift_q[5:0], nx_data_sync_q};
                        cnt_d  = 4'd0;
                        if (shift_q[6]) begin
                            state_d = s_WDATA;
                        end else begin
                            re_d    = 1'b1;
                            state_d = s_TURN;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            s_WDATA: begin
                if (rise) begin
                    shift_d = {shift_q[14:0], nx_data_sync_q};
                    if (cnt_q == 4'd15) begin
                        wdata_d = {shift_q[14:0], nx_data_sync_q};
                        we_d    = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = s_HDR;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            s_TURN: begin
                // Read data is valid the cycle after the read strobe.
                if (re_q) begin
                    cap_pend_d = 1'b1;
                end
                if (cap_pend_q) begin
                    shift_d = i_reg_rdata;
                end
                if (rise) begin
                    cnt_d   = 4'd0;
                    state_d = s_RDATA;
                end
            end

            s_RDATA: begin
                if (fall) begin
                    oe_d      = 1'b1;
                    nx_data_d = shift_q[15];
                    shift_d   = {shift_q[14:0], 1'b0};
                end
                if (rise) begin
                    if (cnt_q == 4'd15) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = s_HDR;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            default: begin
                cnt_d   = 4'd0;
                state_d = s_HDR;
            end
        endcase

`ifdef NXU8_TARGET_TIMEOUT_EN
        frame_err_d = 1'b0;
        if (rise || fall || !busy) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + 1'b1;
        end
        // Abort once TIMEOUT_CYCLES edge-free cycles have elapsed mid-frame.
        if (busy && !(rise || fall) && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1))) begin
            state_d     = s_HDR;
            cnt_d       = 4'd0;
            oe_d        = 1'b0;
            we_d        = 1'b0;
            re_d        = 1'b0;
            cap_pend_d  = 1'b0;
            frame_err_d = 1'b1;
            idle_d      = '0;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!i_rst_n) begin
            nx_clk_meta_q  <= 1'b0;
            nx_clk_sync_q  <= 1'b0;
            nx_clk_prev_q  <= 1'b0;
            nx_data_meta_q <= 1'b0;
            nx_data_sync_q <= 1'b0;
            state_q        <= s_HDR;
            cnt_q          <= 4'd0;
            shift_q        <= 16'd0;
            cap_pend_q     <= 1'b0;
            addr_q         <= 7'd0;
            wdata_q        <= 16'd0;
            we_q           <= 1'b0;
            re_q           <= 1'b0;
            nx_data_q      <= 1'b0;
            oe_q           <= 1'b0;
`ifdef NXU8_TARGET_TIMEOUT_EN
            idle_q         <= '0;
            frame_err_q    <= 1'b0;
`endif
        end else begin
            nx_clk_meta_q  <= nx_clk_meta_d;
            nx_clk_sync_q  <= nx_clk_sync_d;
            nx_clk_prev_q  <= nx_clk_prev_d;
            nx_data_meta_q <= nx_data_meta_d;
            nx_data_sync_q <= nx_data_sync_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            cap_pend_q     <= cap_pend_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            we_q           <= we_d;
            re_q           <= re_d;
            nx_data_q      <= nx_data_d;
            oe_q           <= oe_d;
`ifdef NXU8_TARGET_TIMEOUT_EN
            idle_q         <= idle_d;
            frame_err_q    <= frame_err_d;
`endif
        end
    end

    assign o_nx_data    = nx_data_q;
    assign o_nx_data_oe = oe_q;
    assign o_reg_addr   = addr_q;
    assign o_reg_wdata  = wdata_q;
    assign o_reg_we     = we_q;
    assign o_reg_re     = re_q;
    assign o_busy       = busy;
`ifdef NXU8_TARGET_TIMEOUT_EN
    assign o_frame_err  = frame_err_q;
`else
    assign o_frame_err  = 1'b0;
`endif

endmodule

// File: doc/nxu8_target.md
NXU8_TARGET -- requirements
Module: nxu8_target

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning i_clk cycles without an nX clock edge mid-frame before the frame aborts (used only with NXU8_TARGET_TIMEOUT_EN).
REQ-002 SHALL have ports:
  - i_clk  in  1  system clock, the single clock
  - i_rst_n  in  1  synchronous active-low reset
  - i_nx_clk  in  1  nX-U8 debug clock from the host; asynchronous to i_clk
  - i_nx_data  in  1  data pin input
  - o_nx_data  out  1  data pin output value
  - o_nx_data_oe  out  1  data pin output enable, 1 = target drives the pin
  - o_reg_addr  out  7  register address
  - o_reg_wdata  out  16  register write data
  - o_reg_we  out  1  one-cycle write strobe
  - o_reg_re  out  1  one-cycle read strobe
  - i_reg_rdata  in  16  read data, valid 1 cycle after o_reg_re
  - o_busy  out  1  frame in progress
  - o_frame_err  out  1  one-cycle pulse on an aborted frame

Function
REQ-003 SHALL pass i_nx_clk and i_nx_data through 2-flop synchronizers; rise = synced clk 0->1, fall = synced clk 1->0, detected on i_clk.
REQ-004 SHALL sample synced data on each detected rise; all frame fields MSB first.
REQ-005 Frame SHALL be an 8-bit header (bit7 = write, bits6:0 = address), then 16 write-data bits (write) or 1 turnaround rise plus 16 read-data bits (read).
REQ-006 FSM states SHALL be s_HDR, s_WDATA, s_TURN, s_RDATA, with a bit counter (0..15) cleared on every state entry.
REQ-007 s_HDR: on the 8th rise, latch o_reg_addr; if bit7=1 go to s_WDATA, else pulse o_reg_re for 1 cycle and go to s_TURN.
REQ-008 s_TURN: capture i_reg_rdata into the shift register on the cycle after o_reg_re; go to s_RDATA on the next rise.
REQ-009 s_RDATA: on each fall assert o_nx_data_oe and drive the next shift bit, bit15 first; after the 16th rise deassert o_nx_data_oe on the next cycle and go to s_HDR.
REQ-010 s_WDATA: shift in 16 bits; on the cycle after the 16th rise, pulse o_reg_we for 1 cycle with o_reg_wdata = the assembled word; go to s_HDR.
REQ-011 o_reg_addr and o_reg_wdata SHALL hold their values until the next header or write completes.
REQ-012 o_nx_data_oe SHALL be 0 in every state except s_RDATA.
REQ-013 o_busy SHALL be 1 from the first header rise until the frame returns to s_HDR with the counter at 0.
REQ-014 Back-to-back frames SHALL decode with no idle nX clocks between them.
REQ-015 o_reg_we and o_reg_re SHALL never both be 1 in the same cycle.

Reset
REQ-016 On i_rst_n=0 at a clock edge: state s_HDR, counter 0, synchronizers 0, shift register 0, all outputs 0 (o_nx_data_oe=0 on the following edge).
REQ-017 Reset mid-frame SHALL discard the partial frame with no strobe issued; decoding restarts at the next header.

Configuration
REQ-018 With NXU8_TARGET_TIMEOUT_EN defined: an idle counter clears on every rise or fall; if it reaches TIMEOUT_CYCLES while o_busy=1, the FSM returns to s_HDR, o_nx_data_oe goes to 0, o_frame_err pulses 1 cycle, and no strobe is issued.
REQ-019 Without NXU8_TARGET_TIMEOUT_EN: no idle counter; frames never abort except by reset; o_frame_err is tied to 0.

Verification
REQ-020 Write header 0x85, data 0xBEEF -> one o_reg_we pulse with o_reg_addr=0x05, o_reg_wdata=0xBEEF; o_nx_data_oe stays 0.
REQ-021 Read header 0x12, i_reg_rdata=0xA55A -> one o_reg_re pulse with addr 0x12; host samples 1010010101011010 on the 16 data rises; oe drops after the last rise.
REQ-022 Write 0x81/0x1234 followed immediately by read 0x01 -> we (0x01, 0x1234), then re (0x01); no overlap.
REQ-023 Assert i_rst_n=0 after the 5th read-data rise -> oe=0 on the next edge, no further strobes; a following write 0x83/0x00FF decodes correctly.
REQ-024 TIMEOUT_EN, TIMEOUT_CYCLES=16: 3 header bits then 16 idle cycles -> o_frame_err pulse, o_busy=0; the next full frame decodes correctly.
REQ-025 Without TIMEOUT_EN: the same stall of 5000 cycles, then the remaining 5 header bits -> the frame completes normally and o_frame_err stays 0.
